// File: rtl/timeout_recovery_scheduler_if.sv
// Handshake bundle between the timeout recovery scheduler and the tracker,
// the retry engine and the error logger.
interface timeout_recovery_scheduler_if;
  logic        warn_valid;
  logic [11:0] warn_txn_id;
  logic        to_valid;
  logic [11:0] to_txn_id;
  logic [7:0]  to_src_id;
  logic [7:0]  to_tgt_id;
  logic [47:0] to_addr;
  logic        retry_req_valid;
  logic        retry_req_ready;
  logic [11:0] retry_req_txn_id;
  logic        retry_done;
  logic        retry_ok;
  logic        recovery_action;
  logic [11:0] recovery_txn_id;
  logic        err_valid;
  logic        err_ready;
  logic [1:0]  err_code;
  logic [11:0] err_txn_id;
  logic [7:0]  err_src_id;
  logic [7:0]  err_tgt_id;
  logic [47:0] err_addr;
  logic [15:0] warn_drop_count;
  logic [15:0] to_drop_count;
  logic        busy;

  modport slave (
    input  warn_valid, warn_txn_id, to_valid, to_txn_id, to_src_id, to_tgt_id, to_addr,
           retry_req_ready, retry_done, retry_ok, err_ready,
    output retry_req_valid, retry_req_txn_id, recovery_action, recovery_txn_id,
           err_valid, err_code, err_txn_id, err_src_id, err_tgt_id, err_addr,
           warn_drop_count, to_drop_count, busy
  );

  modport master (
    output warn_valid, warn_txn_id, to_valid, to_txn_id, to_src_id, to_tgt_id, to_addr,
           retry_req_ready, retry_done, retry_ok, err_ready,
    input  retry_req_valid, retry_req_txn_id, recovery_action, recovery_txn_id,
           err_valid, err_code, err_txn_id, err_src_id, err_tgt_id, err_addr,
           warn_drop_count, to_drop_count, busy
  );
endinterface

// File: rtl/timeout_recovery_scheduler.sv
// Recovery sequencer: queues warnings, retries under a per-txn budget,
// and escalates exhausted retries and hard timeouts to the error channel.
module timeout_recovery_scheduler #(
  parameter int WARN_DEPTH        = 8,
  parameter int TO_DEPTH          = 4,
  parameter int TRACK_ENTRIES     = 16,
  parameter int MAX_RETRIES       = 3,
  parameter int RETRY_WAIT_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  timeout_recovery_scheduler_if.slave bus
);
  localparam int WAW = $clog2(WARN_DEPTH);
  localparam int TAW = $clog2(TO_DEPTH);
  localparam int TIW = (TRACK_ENTRIES > 1) ? $clog2(TRACK_ENTRIES) : 1;
  localparam int WDW = $clog2(RETRY_WAIT_CYCLES + 1);
  localparam logic [WAW:0]   WQ_FULL = (WAW+1)'(WARN_DEPTH);
  localparam logic [TAW:0]   TQ_FULL = (TAW+1)'(TO_DEPTH);
  localparam logic [3:0]     MAXR    = 4'(MAX_RETRIES);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(RETRY_WAIT_CYCLES);
  localparam logic [TIW-1:0] RR_LAST = TIW'(TRACK_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REQ, S_WAIT, S_RECOVER, S_ESCALATE
  } state_t;

  state_t         state_q;
  logic [11:0]    wq_mem_q [WARN_DEPTH];
  logic [WAW-1:0] wq_rd_q, wq_wr_q;
  logic [WAW:0]   wq_cnt_q;
  logic [11:0]    tq_txn_q  [TO_DEPTH];
  logic [7:0]     tq_src_q  [TO_DEPTH];
  logic [7:0]     tq_tgt_q  [TO_DEPTH];
  logic [47:0]    tq_addr_q [TO_DEPTH];
  logic [TAW-1:0] tq_rd_q, tq_wr_q;
  logic [TAW:0]   tq_cnt_q;
  logic           tbl_v_q   [TRACK_ENTRIES];
  logic [11:0]    tbl_id_q  [TRACK_ENTRIES];
  logic [3:0]     tbl_cnt_q [TRACK_ENTRIES];
  logic [TIW-1:0] rr_q;
  logic [11:0]    work_id_q;
  logic [TIW-1:0] work_idx_q;
  logic [WDW-1:0] wd_q;
  logic           req_valid_q, rec_q;
  logic [11:0]    rec_id_q;
  logic           err_valid_q, err_is_esc_q;
  logic [1:0]     err_code_q;
  logic [11:0]    err_txn_q;
  logic [7:0]     err_src_q, err_tgt_q;
  logic [47:0]    err_addr_q;
  logic [15:0]    wdrop_q, tdrop_q;

  logic           hit, free_found;
  logic [TIW-1:0] hit_idx, free_idx;
  logic           wq_pop, wq_push, tq_pop, tq_push, err_accept;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < TRACK_ENTRIES; i++) begin
      if (tbl_v_q[i] && (tbl_id_q[i] == work_id_q) && !hit) begin
        hit     = 1'b1;
        hit_idx = TIW'(i);
      end
      if (!tbl_v_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = TIW'(i);
      end
    end
  end

  // A same-cycle pop frees a slot, so a push into a full queue is still taken.
  always_comb begin
    err_accept = err_valid_q && bus.err_ready;
    wq_pop     = (state_q == S_IDLE) && (wq_cnt_q != '0);
    wq_push    = bus.warn_valid && ((wq_cnt_q != WQ_FULL) || wq_pop);
    tq_pop     = err_accept && !err_is_esc_q;
    tq_push    = bus.to_valid && ((tq_cnt_q != TQ_FULL) || tq_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wq_rd_q      <= '0;
      wq_wr_q      <= '0;
      wq_cnt_q     <= '0;
      tq_rd_q      <= '0;
      tq_wr_q      <= '0;
      tq_cnt_q     <= '0;
      rr_q         <= '0;
      work_id_q    <= '0;
      work_idx_q   <= '0;
      wd_q         <= '0;
      req_valid_q  <= 1'b0;
      rec_q        <= 1'b0;
      rec_id_q     <= '0;
      err_valid_q  <= 1'b0;
      err_is_esc_q <= 1'b0;
      err_code_q   <= '0;
      err_txn_q    <= '0;
      err_src_q    <= '0;
      err_tgt_q    <= '0;
      err_addr_q   <= '0;
      wdrop_q      <= '0;
      tdrop_q      <= '0;
      for (int unsigned i = 0; i < WARN_DEPTH; i++) wq_mem_q[i] <= '0;
      for (int unsigned i = 0; i < TO_DEPTH; i++) begin
        tq_txn_q[i]  <= '0;
        tq_src_q[i]  <= '0;
        tq_tgt_q[i]  <= '0;
        tq_addr_q[i] <= '0;
      end
      for (int unsigned i = 0; i < TRACK_ENTRIES; i++) begin
        tbl_v_q[i]   <= 1'b0;
        tbl_id_q[i]  <= '0;
        tbl_cnt_q[i] <= '0;
      end
    end else begin
      if (wq_push) begin
        wq_mem_q[wq_wr_q] <= bus.warn_txn_id;
        wq_wr_q           <= wq_wr_q + 1'b1;
      end
      if (wq_pop) wq_rd_q <= wq_rd_q + 1'b1;
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt_q <= wq_cnt_q + 1'b1;
        2'b01:   wq_cnt_q <= wq_cnt_q - 1'b1;
        default: wq_cnt_q <= wq_cnt_q;
      endcase
      if (bus.warn_valid && !wq_push && (wdrop_q != '1)) wdrop_q <= wdrop_q + 1'b1;

      if (tq_push) begin
        tq_txn_q[tq_wr_q]  <= bus.to_txn_id;
        tq_src_q[tq_wr_q]  <= bus.to_src_id;
        tq_tgt_q[tq_wr_q]  <= bus.to_tgt_id;
        tq_addr_q[tq_wr_q] <= bus.to_addr;
        tq_wr_q            <= tq_wr_q + 1'b1;
      end
      if (tq_pop) tq_rd_q <= tq_rd_q + 1'b1;
      case ({tq_push, tq_pop})
        2'b10:   tq_cnt_q <= tq_cnt_q + 1'b1;
        2'b01:   tq_cnt_q <= tq_cnt_q - 1'b1;
        default: tq_cnt_q <= tq_cnt_q;
      endcase
      if (bus.to_valid && !tq_push && (tdrop_q != '1)) tdrop_q <= tdrop_q + 1'b1;

      // Timeout invalidation is written before the FSM so a LOOKUP update to the same entry wins.
      if (err_accept) begin
        err_valid_q <= 1'b0;
        if (!err_is_esc_q) begin
          for (int unsigned i = 0; i < TRACK_ENTRIES; i++)
            if (tbl_v_q[i] && (tbl_id_q[i] == err_txn_q)) tbl_v_q[i] <= 1'b0;
        end
      end else if (!err_valid_q) begin
        if (tq_cnt_q != '0) begin
          err_valid_q  <= 1'b1;
          err_is_esc_q <= 1'b0;
          err_code_q   <= 2'b10;
          err_txn_q    <= tq_txn_q[tq_rd_q];
          err_src_q    <= tq_src_q[tq_rd_q];
          err_tgt_q    <= tq_tgt_q[tq_rd_q];
          err_addr_q   <= tq_addr_q[tq_rd_q];
        end else if (state_q == S_ESCALATE) begin
          err_valid_q  <= 1'b1;
          err_is_esc_q <= 1'b1;
          err_code_q   <= 2'b01;
          err_txn_q    <= work_id_q;
          err_src_q    <= '0;
          err_tgt_q    <= '0;
          err_addr_q   <= '0;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (wq_pop) begin
            work_id_q <= wq_mem_q[wq_rd_q];
            state_q   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit && (tbl_cnt_q[hit_idx] >= MAXR)) begin
            work_idx_q <= hit_idx;
            state_q    <= S_ESCALATE;
          end else begin
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
            if (hit) begin
              tbl_cnt_q[hit_idx] <= tbl_cnt_q[hit_idx] + 1'b1;
              work_idx_q         <= hit_idx;
            end else if (free_found) begin
              tbl_v_q[free_idx]   <= 1'b1;
              tbl_id_q[free_idx]  <= work_id_q;
              tbl_cnt_q[free_idx] <= 4'd1;
              work_idx_q          <= free_idx;
            end else begin
              tbl_v_q[rr_q]   <= 1'b1;
              tbl_id_q[rr_q]  <= work_id_q;
              tbl_cnt_q[rr_q] <= 4'd1;
              work_idx_q      <= rr_q;
              rr_q            <= (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.retry_req_ready) begin
            req_valid_q <= 1'b0;
            wd_q        <= WD_LOAD;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          wd_q <= wd_q - 1'b1;
          if (bus.retry_done) begin
            if (bus.retry_ok) begin
              rec_q    <= 1'b1;
              rec_id_q <= work_id_q;
              state_q  <= S_RECOVER;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (wd_q == WDW'(1)) begin
            state_q <= S_IDLE;
          end
        end
        S_RECOVER: begin
          rec_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ESCALATE: begin
          if (err_accept && err_is_esc_q) begin
            tbl_v_q[work_idx_q] <= 1'b0;
            state_q             <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.retry_req_valid  = req_valid_q;
  assign bus.retry_req_txn_id = work_id_q;
  assign bus.recovery_action  = rec_q;
  assign bus.recovery_txn_id  = rec_id_q;
  assign bus.err_valid        = err_valid_q;
  assign bus.err_code         = err_code_q;
  assign bus.err_txn_id       = err_txn_q;
  assign bus.err_src_id       = err_src_q;
  assign bus.err_tgt_id       = err_tgt_q;
  assign bus.err_addr         = err_addr_q;
  assign bus.warn_drop_count  = wdrop_q;
  assign bus.to_drop_count    = tdrop_q;
  assign bus.busy             = (state_q != S_IDLE);
endmodule

// File: doc/timeout_recovery_scheduler.md
Name: timeout_recovery_scheduler

Overview:
- Sequences recovery for transactions flagged by the transaction timeout tracker.
- Queues warning events, issues retry requests to the retry engine under a per-transaction retry budget, and pulses recovery_action back to the tracker on success.
- Escalates exhausted retries and hard timeouts to the error reporting channel.
- Sits between the timeout tracker, the retry engine and the error/interrupt logger.

Parameters:
- WARN_DEPTH, 8, warning queue entries (power of 2, ≥2)
- TO_DEPTH, 4, hard-timeout queue entries (power of 2, ≥2)
- TRACK_ENTRIES, 16, retry-count table entries
- MAX_RETRIES, 3, retries allowed per txn_id before escalation (1..15)
- RETRY_WAIT_CYCLES, 64, watchdog on retry engine response

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- warn_valid  in  1  single-cycle warning event
- warn_txn_id  in  12  warned transaction ID
- to_valid  in  1  single-cycle hard-timeout event
- to_txn_id  in  12  timed-out transaction ID
- to_src_id  in  8  source node of timed-out transaction
- to_tgt_id  in  8  target node of timed-out transaction
- to_addr  in  48  address of timed-out transaction
- retry_req_valid  out  1  retry request
- retry_req_ready  in  1  retry engine accepts request
- retry_req_txn_id  out  12  transaction to retry
- retry_done  in  1  single-cycle retry completion
- retry_ok  in  1  retry succeeded; qualified by retry_done
- recovery_action  out  1  single-cycle pulse to the tracker
- recovery_txn_id  out  12  transaction whose timer is restarted
- err_valid  out  1  error record valid
- err_ready  in  1  logger accepts record
- err_code  out  2  01 = retries exhausted, 10 = hard timeout
- err_txn_id  out  12  error record transaction ID
- err_src_id  out  8  error record source node
- err_tgt_id  out  8  error record target node
- err_addr  out  48  error record address
- warn_drop_count  out  16  warnings dropped on full queue, saturating
- to_drop_count  out  16  timeouts dropped on full queue, saturating
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, both queues empty, retry table invalid, FSM in IDLE.
- Reset mid-operation abandons any in-flight request or record without completion.
- Warning queue is a FIFO.
  - Push on warn_valid when not full.
  - When full, the event is dropped and warn_drop_count increments.
- Timeout queue is a FIFO.
  - Push on to_valid when not full.
  - When full, the event is dropped and to_drop_count increments.
- Both drop counters saturate at 16'hFFFF.
- A push and a pop in the same cycle on a full queue: the push is accepted.
- Retry table: TRACK_ENTRIES entries of {valid, txn_id, cnt[3:0]}.
- FSM states: IDLE, LOOKUP, REQ, WAIT, RECOVER, ESCALATE.
- IDLE: when the warning queue is non-empty, pop the head into a working register and go to LOOKUP.
- LOOKUP (1 cycle): search the table for the working txn_id.
  - Hit with cnt ≥ MAX_RETRIES: go to ESCALATE.
  - Hit with cnt < MAX_RETRIES: cnt += 1, go to REQ.
  - Miss: allocate the lowest invalid entry with cnt=1. If the table is full, replace the entry at a round-robin pointer, then advance the pointer. Go to REQ.
- REQ: assert retry_req_valid with retry_req_txn_id held stable until the cycle retry_req_ready=1, then go to WAIT.
  - Load the watchdog with RETRY_WAIT_CYCLES on entry to WAIT.
- WAIT: decrement the watchdog each cycle.
  - retry_done with retry_ok=1: go to RECOVER.
  - retry_done with retry_ok=0: go to IDLE.
  - Watchdog reaches 0: go to IDLE; the attempt counts as failed.
  - retry_done in the expiry cycle takes precedence over expiry.
- RECOVER (1 cycle): recovery_action=1, recovery_txn_id = working ID, then go to IDLE. The table entry is kept, so the budget spans re-warnings.
- ESCALATE: request the error channel with err_code=01, the working txn_id, and src/tgt/addr = 0.
  - Invalidate the table entry when the record is accepted, then go to IDLE.
- Error channel arbitration:
  - The timeout queue head (err_code=10, full fields) has priority over ESCALATE.
  - A record, once presented with err_valid=1, holds all fields stable until err_ready. No preemption.
  - Timeout queue pop occurs on acceptance.
  - Accepting a timeout record invalidates any table entry matching its txn_id.
  - This path is independent of the FSM, except for the shared channel.
- Simultaneous table updates to the same entry in one cycle: LOOKUP update wins over timeout invalidation.
- busy = (state ≠ IDLE).

Test Plan:
- warn 0x123, retry_req_ready=1, retry_done+retry_ok=1 after 5 cycles -> one retry_req for 0x123, then recovery_action pulse with recovery_txn_id=0x123; table cnt=1.
- Warn 0x0AA four times, each retry ok, MAX_RETRIES=3 -> three recovery_action pulses, then err_valid with err_code=01, txn 0x0AA; entry freed after err_ready.
- No retry_done after request -> return to IDLE exactly RETRY_WAIT_CYCLES=64 cycles after acceptance; no recovery_action.
- 10 back-to-back warns with the FSM stalled (retry_req_ready=0) -> 8 queued, warn_drop_count=2.
- to_valid (0x055, src 0x03, tgt 0x07, addr 0x1000) while ESCALATE is pending with err_ready=0 and err_valid not yet asserted -> timeout record (err_code=10) presented first, escalation record after it.
- Assert rst_n=0 during REQ -> all outputs 0 immediately; after reset, busy=0 and no stale retry_req.
